// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shifter: accepts one request, shifts one bit per cycle,
// then presents the result until the consumer acknowledges it.
module shift_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [7:0] data,
   input  logic [7:0] amount,
   output logic       ready,
   output logic       busy,
   output logic [7:0] result,
   output logic       valid,
   input  logic       ack
);

   localparam logic [1:0] OpSll = 2'b00;
   localparam logic [1:0] OpSrl = 2'b01;
   localparam logic [1:0] OpSra = 2'b10;
   localparam logic [1:0] OpRor = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e     state_q;
   logic [7:0] work_q;
   logic [3:0] cnt_q;
   logic [1:0] op_q;

   logic [3:0] eff_cnt;
   logic [7:0] shifted;

   // Effective count: linear shifts saturate at 8 (result fully shifted out),
   // rotates wrap modulo 8 so a multiple of 8 costs no shift cycles.
   always_comb begin
      eff_cnt = 4'd0;
      if (op == OpRor) begin
         eff_cnt = {1'b0, amount[2:0]};
      end else if (amount >= 8'd8) begin
         eff_cnt = 4'd8;
      end else begin
         eff_cnt = amount[3:0];
      end
   end

   // One-bit step of the working register for the latched operation.
   always_comb begin
      shifted = work_q;
      unique case (op_q)
         OpSll:   shifted = {work_q[6:0], 1'b0};
         OpSrl:   shifted = {1'b0, work_q[7:1]};
         OpSra:   shifted = {work_q[7], work_q[7:1]};
         OpRor:   shifted = {work_q[0], work_q[7:1]};
         default: shifted = work_q;
      endcase
   end

   // Control FSM with registered handshake outputs; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         work_q  <= 8'h00;
         cnt_q   <= 4'd0;
         op_q    <= OpSll;
         ready   <= 1'b1;
         busy    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  work_q <= data;
                  cnt_q  <= eff_cnt;
                  op_q   <= op;
                  ready  <= 1'b0;
                  if (eff_cnt == 4'd0) begin
                     state_q <= StDone;
                     valid   <= 1'b1;
                  end else begin
                     state_q <= StShift;
                     busy    <= 1'b1;
                  end
               end
            end
            StShift: begin
               work_q <= shifted;
               cnt_q  <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  valid   <= 1'b1;
               end
            end
            StDone: begin
               // start is deliberately not looked at here, even with ack high
               if (ack) begin
                  state_q <= StIdle;
                  valid   <= 1'b0;
                  ready   <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               ready   <= 1'b1;
               busy    <= 1'b0;
               valid   <= 1'b0;
            end
         endcase
      end
   end

   assign result = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results,
// a negedge monitor pops one per VALID window and checks it stays held.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] op;
   logic [7:0] data;
   logic [7:0] amount;
   logic       ready;
   logic       busy;
   logic [7:0] result;
   logic       valid;
   logic       ack;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   shift_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .data   (data),
      .amount (amount),
      .ready  (ready),
      .busy   (busy),
      .result (result),
      .valid  (valid),
      .ack    (ack)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: first VALID cycle pops the scoreboard, later cycles check hold.
   logic       seen = 1'b0;
   logic [7:0] cur = 8'h00;
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: got result %0h expected no VALID", result);
               cur = result;
            end else begin
               cur = sb.pop_front();
               check("sb_result", {24'h0, result}, {24'h0, cur});
            end
         end else begin
            check("hold_result", {24'h0, result}, {24'h0, cur});
         end
      end else begin
         seen = 1'b0;
      end
   end

   // Issue one request, check shift-cycle count and latency, then acknowledge.
   task automatic run_op(input logic [1:0] o, input logic [7:0] d, input logic [7:0] a,
                         input logic [7:0] exp, input int n, input int hold, input bit pulse);
      int t;
      int cyc;
      t = 0;
      while (ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_start", {31'h0, ready}, 32'h1);
      start  = 1'b1;
      op     = o;
      data   = d;
      amount = a;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (!pulse) start = 1'b0;
      // Operands change right after accept; the operation must not notice.
      data   = ~d;
      amount = 8'h03;
      op     = ~o;
      @(negedge clk);
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      check("shift_cycles", cyc, n);
      check("valid_after_latency", {31'h0, valid}, 32'h1);
      repeat (hold) begin
         @(negedge clk);
         check("valid_held", {31'h0, valid}, 32'h1);
      end
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("ready_after_ack", {31'h0, ready}, 32'h1);
      check("valid_after_ack", {31'h0, valid}, 32'h0);
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b1;
      op     = 2'b00;
      data   = 8'hAA;
      amount = 8'h02;
      ack    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // start held high during reset must not be accepted
      check("rst_ready", {31'h0, ready}, 32'h1);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_result", {24'h0, result}, 32'h0);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'h0, ready}, 32'h1);

      // SRL B4 by 3, held 2 extra cycles
      run_op(2'b01, 8'hB4, 8'd3, 8'h16, 3, 2, 1'b0);
      // Saturating shifts
      run_op(2'b10, 8'h80, 8'd200, 8'hFF, 8, 0, 1'b0);
      run_op(2'b00, 8'hFF, 8'd9, 8'h00, 8, 0, 1'b0);
      run_op(2'b01, 8'hFF, 8'd8, 8'h00, 8, 0, 1'b0);
      run_op(2'b10, 8'h7F, 8'd8, 8'h00, 8, 0, 1'b0);
      // Rotates
      run_op(2'b11, 8'h81, 8'd9, 8'hC0, 1, 0, 1'b0);
      run_op(2'b11, 8'h81, 8'd8, 8'h81, 0, 0, 1'b0);
      run_op(2'b11, 8'h5A, 8'd16, 8'h5A, 0, 1, 1'b0);
      // Zero-count linear shift
      run_op(2'b00, 8'h81, 8'd0, 8'h81, 0, 0, 1'b0);
      // Hold 5 cycles with start pulsing through SHIFT and DONE (and the ack cycle)
      run_op(2'b10, 8'h96, 8'd2, 8'hE5, 2, 5, 1'b1);

      // Reset during the 4th SHIFT cycle of SLL by 6
      @(negedge clk);
      start  = 1'b1;
      op     = 2'b00;
      data   = 8'h0F;
      amount = 8'd6;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_4th_shift", {31'h0, busy}, 32'h1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ready", {31'h0, ready}, 32'h1);
      check("midrst_valid", {31'h0, valid}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      check("midrst_result", {24'h0, result}, 32'h0);
      run_op(2'b00, 8'h01, 8'd2, 8'h04, 2, 0, 1'b0);

      // Back-to-back with ack on the first VALID cycle
      run_op(2'b00, 8'h01, 8'd1, 8'h02, 1, 0, 1'b0);
      run_op(2'b01, 8'h80, 8'd7, 8'h01, 7, 0, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 32'h0);
      check("idle_valid", {31'h0, valid}, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
